// File: rtl/histeq_sequencer_if.sv
// Stage handshake and shared m2 scratchpad bundle between histeq_sequencer and its three stages.
// master = sequencer side, slave = stage/scratchpad side.
interface histeq_sequencer_if #(
   parameter int ADDR_W = 16,
   parameter int DATA_W = 128
);
   logic              hist_start;
   logic              cdf_start;
   logic              map_start;
   logic              hist_done;
   logic              cdf_done;
   logic              map_done;

   logic [ADDR_W-1:0] hist_m2ReadAddr;
   logic [ADDR_W-1:0] cdf_m2ReadAddr;
   logic [ADDR_W-1:0] map_m2ReadAddr;
   logic [ADDR_W-1:0] hist_m2WriteAddr;
   logic [ADDR_W-1:0] cdf_m2WriteAddr;
   logic [DATA_W-1:0] hist_m2WriteBus;
   logic [DATA_W-1:0] cdf_m2WriteBus;
   logic              hist_m2WE;
   logic              cdf_m2WE;

   logic [ADDR_W-1:0] m2ReadAddr;
   logic [ADDR_W-1:0] m2WriteAddr;
   logic [DATA_W-1:0] m2WriteBus;
   logic              m2WE;

   modport master (
      output hist_start, cdf_start, map_start,
      input  hist_done, cdf_done, map_done,
      input  hist_m2ReadAddr, cdf_m2ReadAddr, map_m2ReadAddr,
      input  hist_m2WriteAddr, cdf_m2WriteAddr,
      input  hist_m2WriteBus, cdf_m2WriteBus,
      input  hist_m2WE, cdf_m2WE,
      output m2ReadAddr, m2WriteAddr, m2WriteBus, m2WE
   );

   modport slave (
      input  hist_start, cdf_start, map_start,
      output hist_done, cdf_done, map_done,
      output hist_m2ReadAddr, cdf_m2ReadAddr, map_m2ReadAddr,
      output hist_m2WriteAddr, cdf_m2WriteAddr,
      output hist_m2WriteBus, cdf_m2WriteBus,
      output hist_m2WE, cdf_m2WE,
      input  m2ReadAddr, m2WriteAddr, m2WriteBus, m2WE
   );
endinterface

// File: rtl/histeq_sequencer.sv
// Phase controller for the histogram equalizer: runs HIST -> CDF -> MAP, owns the shared m2 port,
// guards each stage with a watchdog. Optional macro HISTEQ_PERF_COUNT_EN adds per-stage cycle counters.
module histeq_sequencer #(
   parameter int          ADDR_W      = 16,
   parameter int          DATA_W      = 128,
   parameter logic [31:0] TIMEOUT     = 32'd1048575,
   parameter int          STAGE_CNT_W = 20
) (
   input  logic                   clock,
   input  logic                   rst,
   input  logic                   go,
   output logic                   busy,
   output logic                   done,
   output logic                   error,
   output logic [1:0]             err_stage,
   output logic                   inputBaseOffset,
`ifdef HISTEQ_PERF_COUNT_EN
   output logic [STAGE_CNT_W-1:0] hist_cycles,
   output logic [STAGE_CNT_W-1:0] cdf_cycles,
   output logic [STAGE_CNT_W-1:0] map_cycles,
`endif
   histeq_sequencer_if.master     bus
);

   localparam logic [STAGE_CNT_W-1:0] WD_LIMIT = STAGE_CNT_W'(TIMEOUT - 32'd1);
   localparam logic [STAGE_CNT_W-1:0] WD_ZERO  = {STAGE_CNT_W{1'b0}};
   localparam logic [STAGE_CNT_W-1:0] WD_ONE   = {{(STAGE_CNT_W-1){1'b0}}, 1'b1};

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_HIST   = 3'd1,
      S_CDF    = 3'd2,
      S_MAP    = 3'd3,
      S_FINISH = 3'd4,
      S_ERROR  = 3'd5
   } state_t;

   state_t                 state_q, state_d;
   logic                   busy_q, busy_d;
   logic                   done_q, done_d;
   logic                   error_q, error_d;
   logic [1:0]             err_stage_q, err_stage_d;
   logic                   offset_q, offset_d;
   logic                   hist_start_q, hist_start_d;
   logic                   cdf_start_q, cdf_start_d;
   logic                   map_start_q, map_start_d;
   logic [STAGE_CNT_W-1:0] wd_q, wd_d;

   logic                   stage_done;
   logic [1:0]             stage_code;
   logic                   wd_expired;

   // Done flag and error code of the stage that currently owns the sequence; other stages' done is ignored.
   always_comb begin
      stage_done = 1'b0;
      stage_code = 2'd0;
      case (state_q)
         S_HIST: begin
            stage_done = bus.hist_done;
            stage_code = 2'd1;
         end
         S_CDF: begin
            stage_done = bus.cdf_done;
            stage_code = 2'd2;
         end
         S_MAP: begin
            stage_done = bus.map_done;
            stage_code = 2'd3;
         end
         default: begin
            stage_done = 1'b0;
            stage_code = 2'd0;
         end
      endcase
   end

   assign wd_expired = (wd_q == WD_LIMIT);

   // State register.
   always_ff @(posedge clock) begin
      if (rst) begin
         state_q <= S_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state logic; a done seen together with an expired watchdog still advances.
   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE: begin
            if (go) state_d = S_HIST;
            else    state_d = S_IDLE;
         end
         S_HIST: begin
            if (stage_done)      state_d = S_CDF;
            else if (wd_expired) state_d = S_ERROR;
            else                 state_d = S_HIST;
         end
         S_CDF: begin
            if (stage_done)      state_d = S_MAP;
            else if (wd_expired) state_d = S_ERROR;
            else                 state_d = S_CDF;
         end
         S_MAP: begin
            if (stage_done)      state_d = S_FINISH;
            else if (wd_expired) state_d = S_ERROR;
            else                 state_d = S_MAP;
         end
         S_FINISH: state_d = S_IDLE;
         S_ERROR:  state_d = S_IDLE;
         default:  state_d = S_IDLE;
      endcase
   end

   // Output and watchdog next values; starts rise only once the state has been held for a cycle.
   always_comb begin
      busy_d      = busy_q;
      done_d      = 1'b0;
      error_d     = error_q;
      err_stage_d = err_stage_q;
      offset_d    = offset_q;
      wd_d        = wd_q;
      case (state_q)
         S_IDLE: begin
            if (go) begin
               busy_d      = 1'b1;
               error_d     = 1'b0;
               err_stage_d = 2'd0;
               wd_d        = WD_ZERO;
            end else begin
               busy_d      = 1'b0;
               wd_d        = WD_ZERO;
            end
         end
         S_HIST, S_CDF, S_MAP: begin
            if (stage_done) begin
               wd_d = WD_ZERO;
            end else if (wd_expired) begin
               wd_d        = WD_ZERO;
               error_d     = 1'b1;
               err_stage_d = stage_code;
            end else begin
               wd_d = wd_q + WD_ONE;
            end
         end
         S_FINISH: begin
            done_d   = 1'b1;
            busy_d   = 1'b0;
            offset_d = ~offset_q;
            wd_d     = WD_ZERO;
         end
         S_ERROR: begin
            busy_d = 1'b0;
            wd_d   = WD_ZERO;
         end
         default: begin
            busy_d = 1'b0;
            wd_d   = WD_ZERO;
         end
      endcase
      hist_start_d = (state_q == S_HIST) && (state_d == S_HIST);
      cdf_start_d  = (state_q == S_CDF)  && (state_d == S_CDF);
      map_start_d  = (state_q == S_MAP)  && (state_d == S_MAP);
   end

   // Registered control outputs and watchdog.
   always_ff @(posedge clock) begin
      if (rst) begin
         busy_q       <= 1'b0;
         done_q       <= 1'b0;
         error_q      <= 1'b0;
         err_stage_q  <= 2'd0;
         offset_q     <= 1'b0;
         hist_start_q <= 1'b0;
         cdf_start_q  <= 1'b0;
         map_start_q  <= 1'b0;
         wd_q         <= WD_ZERO;
      end else begin
         busy_q       <= busy_d;
         done_q       <= done_d;
         error_q      <= error_d;
         err_stage_q  <= err_stage_d;
         offset_q     <= offset_d;
         hist_start_q <= hist_start_d;
         cdf_start_q  <= cdf_start_d;
         map_start_q  <= map_start_d;
         wd_q         <= wd_d;
      end
   end

   assign busy            = busy_q;
   assign done            = done_q;
   assign error           = error_q;
   assign err_stage       = err_stage_q;
   assign inputBaseOffset = offset_q;
   assign bus.hist_start  = hist_start_q;
   assign bus.cdf_start   = cdf_start_q;
   assign bus.map_start   = map_start_q;

   // m2 port routing from registered state; MAP is read-only so its write side stays quiet.
   always_comb begin
      bus.m2ReadAddr  = {ADDR_W{1'b0}};
      bus.m2WriteAddr = {ADDR_W{1'b0}};
      bus.m2WriteBus  = {DATA_W{1'b0}};
      bus.m2WE        = 1'b0;
      case (state_q)
         S_HIST: begin
            bus.m2ReadAddr  = bus.hist_m2ReadAddr;
            bus.m2WriteAddr = bus.hist_m2WriteAddr;
            bus.m2WriteBus  = bus.hist_m2WriteBus;
            bus.m2WE        = bus.hist_m2WE;
         end
         S_CDF: begin
            bus.m2ReadAddr  = bus.cdf_m2ReadAddr;
            bus.m2WriteAddr = bus.cdf_m2WriteAddr;
            bus.m2WriteBus  = bus.cdf_m2WriteBus;
            bus.m2WE        = bus.cdf_m2WE;
         end
         S_MAP: begin
            bus.m2ReadAddr  = bus.map_m2ReadAddr;
            bus.m2WE        = 1'b0;
         end
         default: begin
            bus.m2WE        = 1'b0;
         end
      endcase
   end

`ifdef HISTEQ_PERF_COUNT_EN
   logic [STAGE_CNT_W-1:0] hist_cycles_q, hist_cycles_d;
   logic [STAGE_CNT_W-1:0] cdf_cycles_q, cdf_cycles_d;
   logic [STAGE_CNT_W-1:0] map_cycles_q, map_cycles_d;

   // Capture the watchdog of each stage as it completes; cleared when a new run is accepted.
   always_comb begin
      hist_cycles_d = hist_cycles_q;
      cdf_cycles_d  = cdf_cycles_q;
      map_cycles_d  = map_cycles_q;
      if ((state_q == S_IDLE) && go) begin
         hist_cycles_d = WD_ZERO;
         cdf_cycles_d  = WD_ZERO;
         map_cycles_d  = WD_ZERO;
      end else if (stage_done) begin
         case (state_q)
            S_HIST:  hist_cycles_d = wd_q;
            S_CDF:   cdf_cycles_d  = wd_q;
            S_MAP:   map_cycles_d  = wd_q;
            default: hist_cycles_d = hist_cycles_q;
         endcase
      end else begin
         hist_cycles_d = hist_cycles_q;
      end
   end

   // Per-stage cycle counter registers.
   always_ff @(posedge clock) begin
      if (rst) begin
         hist_cycles_q <= WD_ZERO;
         cdf_cycles_q  <= WD_ZERO;
         map_cycles_q  <= WD_ZERO;
      end else begin
         hist_cycles_q <= hist_cycles_d;
         cdf_cycles_q  <= cdf_cycles_d;
         map_cycles_q  <= map_cycles_d;
      end
   end

   assign hist_cycles = hist_cycles_q;
   assign cdf_cycles  = cdf_cycles_q;
   assign map_cycles  = map_cycles_q;
`endif

endmodule
